// File: rtl/detector_jogada_if.sv
// Player-key bus of the memory-game input conditioner.
// Handshake: jogada_feita is a valid-only strobe with no ready. It is high for
// exactly one clock per debounced press, and the consumer must take
// jogada_valor/jogada_invalida in that same cycle. jogada_valor stays stable
// until the next strobe.
interface detector_jogada_if;
  logic [3:0] chaves;
  logic       enable;
  logic       jogada_feita;
  logic [3:0] jogada_valor;
  logic       jogada_invalida;
  logic [3:0] db_estado;

  modport master (
    output chaves, enable,
    input  jogada_feita, jogada_valor, jogada_invalida, db_estado
  );

  modport slave (
    input  chaves, enable,
    output jogada_feita, jogada_valor, jogada_invalida, db_estado
  );
endinterface

// File: rtl/detector_jogada.sv
// Synchronizes and debounces the four player keys, then emits one
// jogada_feita pulse and a registered value per stable press.
module detector_jogada #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input logic              clock,
  input logic              reset,
  detector_jogada_if.slave bus
);

  // The counter only has to reach DEBOUNCE_CYCLES-1, and it is kept at least 1 bit wide.
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [3:0] {
    ESPERA       = 4'd0,
    FILTRA_PRESS = 4'd1,
    PULSO        = 4'd2,
    PRESSIONADO  = 4'd3,
    FILTRA_SOLTA = 4'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [3:0]      r_sync1;
  logic [3:0]      r_sync2;
  logic [3:0]      r_cand;
  logic [3:0]      w_cand_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_next;
  logic [3:0]      r_valor;
  logic            w_load_valor;

  // Two-flop synchronizer on the raw keys. r_sync2 is the only key view the FSM uses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= 4'd0;
      r_sync2 <= 4'd0;
    end else begin
      r_sync1 <= bus.chaves;
      r_sync2 <= r_sync1;
    end
  end

  // State, candidate, debounce counter and captured value registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ESPERA;
      r_cand  <= 4'd0;
      r_cnt   <= '0;
      r_valor <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cand  <= w_cand_next;
      r_cnt   <= w_cnt_next;
      if (w_load_valor) begin
        r_valor <= r_cand;
      end
    end
  end

  // Next-state logic: filter the press, pulse once, then filter the release.
  always_comb begin
    w_state_next = r_state;
    w_cand_next  = r_cand;
    w_cnt_next   = r_cnt;
    w_load_valor = 1'b0;
    case (r_state)
      ESPERA: begin
        if (bus.enable && (r_sync2 != 4'd0)) begin
          w_cand_next  = r_sync2;
          w_cnt_next   = '0;
          w_state_next = FILTRA_PRESS;
        end
      end
      FILTRA_PRESS: begin
        if (r_sync2 == 4'd0) begin
          w_state_next = ESPERA;
        end else if (r_sync2 != r_cand) begin
          // A different key combination restarts the filter on the new value.
          w_cand_next = r_sync2;
          w_cnt_next  = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_load_valor = 1'b1;
          w_state_next = PULSO;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      PULSO: begin
        w_state_next = PRESSIONADO;
      end
      PRESSIONADO: begin
        // Other non-zero values are ignored until the keys are fully released.
        if (r_sync2 == 4'd0) begin
          w_cnt_next   = '0;
          w_state_next = FILTRA_SOLTA;
        end
      end
      FILTRA_SOLTA: begin
        if (r_sync2 != 4'd0) begin
          w_state_next = PRESSIONADO;
        end else if (r_cnt == CNT_MAX) begin
          w_state_next = ESPERA;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = ESPERA;
      end
    endcase
  end

  // Moore outputs decoded from the state. The value output comes straight from its register.
  always_comb begin
    bus.jogada_feita    = (r_state == PULSO);
    bus.jogada_invalida = (r_state == PULSO) && ($countones(r_cand) > 1);
    bus.jogada_valor    = r_valor;
    bus.db_estado       = r_state;
  end

endmodule
